// File: rtl/usr_pkg.sv
// Shared definitions for the serial link: receiver FSM encoding
// and the bit-order selects used by both ends of the link.
package usr_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    FULL  = 2'd2
  } state_t;

  localparam logic DIR_LSB_FIRST = 1'b0;
  localparam logic DIR_MSB_FIRST = 1'b1;

endpackage

// File: rtl/sipo_shift.sv
// Serial-in parallel-out register with bit-order select.
// o_next is the value the register takes on an enabled shift.
import usr_pkg::*;

module sipo_shift #(
  parameter int size = 4
) (
  input  logic            clk,
  input  logic            clear_n,
  input  logic            i_clr,
  input  logic            i_en,
  input  logic            i_dir,
  input  logic            i_sin,
  output logic [size-1:0] o_q,
  output logic [size-1:0] o_next
);

  logic [size-1:0] r_sr;
  logic [size-1:0] w_next;

  always_comb begin
    w_next = {i_sin, r_sr[size-1:1]};
    if (i_dir == DIR_MSB_FIRST)
      w_next = {r_sr[size-2:0], i_sin};
  end

  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) begin
      r_sr <= '0;
    end else if (i_clr) begin
      r_sr <= '0;
    end else if (i_en) begin
      r_sr <= w_next;
    end
  end

  assign o_q    = r_sr;
  assign o_next = w_next;

endmodule

// File: rtl/usr_serial_receiver.sv
// Serial link receiver: deserializes framed bits into size-bit
// words and presents them on a valid/ready output.
import usr_pkg::*;

module usr_serial_receiver #(
  parameter int size = 4
) (
  input  logic            clk,
  input  logic            clear_n,
  input  logic            start,
  input  logic            dir,
  input  logic            bit_en,
  input  logic            sin,
  input  logic            o_ready,
  output logic [size-1:0] o,
  output logic            o_valid,
  output logic            busy,
  output logic            overrun
);

  localparam int CW = $clog2(size);
  localparam logic [CW-1:0] LAST = CW'(size - 1);

  state_t          r_state;
  logic [CW-1:0]   r_cnt;
  logic            r_dir_q;
  logic [size-1:0] r_o;
  logic            r_o_valid;
  logic            r_overrun;

  logic            w_take;
  logic            w_start_ok;
  logic            w_shift_en;
  logic            w_slot_free;
  logic [size-1:0] w_sr;
  logic [size-1:0] w_next;

  assign w_take      = r_o_valid && o_ready;
  assign w_start_ok  = start && (r_state != FULL);
  assign w_shift_en  = (r_state == SHIFT) && bit_en && !start;
  assign w_slot_free = !r_o_valid || o_ready;

  sipo_shift #(
    .size(size)
  ) u_sipo (
    .clk    (clk),
    .clear_n(clear_n),
    .i_clr  (w_start_ok),
    .i_en   (w_shift_en),
    .i_dir  (r_dir_q),
    .i_sin  (sin),
    .o_q    (w_sr),
    .o_next (w_next)
  );

  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_dir_q   <= DIR_LSB_FIRST;
      r_o       <= '0;
      r_o_valid <= 1'b0;
      r_overrun <= 1'b0;
    end else begin
      // a consumed word empties the slot unless refilled below
      if (w_take)
        r_o_valid <= 1'b0;
      unique case (r_state)
        IDLE: begin
          if (start) begin
            r_state   <= SHIFT;
            r_cnt     <= '0;
            r_dir_q   <= dir;
            r_overrun <= 1'b0;
          end
        end
        SHIFT: begin
          if (start) begin
            r_cnt   <= '0;
            r_dir_q <= dir;
          end else if (bit_en) begin
            if (r_cnt == LAST) begin
              r_cnt <= '0;
              if (w_slot_free) begin
                r_o       <= w_next;
                r_o_valid <= 1'b1;
                r_state   <= IDLE;
              end else begin
                r_state <= FULL;
              end
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
        end
        FULL: begin
          if (bit_en || start)
            r_overrun <= 1'b1;
          if (w_take) begin
            r_o       <= w_sr;
            r_o_valid <= 1'b1;
            r_state   <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign o       = r_o;
  assign o_valid = r_o_valid;
  assign busy    = (r_state != IDLE);
  assign overrun = r_overrun;

endmodule
